fp12_inverse: RTL and testbench

FP12_INVERSE -- requirements
Module: fp12_inverse

---
 rtl/fp12_pkg.sv | 29 ++
 rtl/fp12_recip_lut.sv | 17 +
 rtl/fp12_inverse.sv | 109 ++++++++++
 tb/tb_fp12_inverse.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp12_pkg.sv
// Shared widths, constants and helpers for the FP12 -> binary16 reciprocal datapath.
// Subnormal FP12 operands are normalized only when FP12_INV_SUBNORM_EN is defined.
package fp12_pkg;

  localparam int EXP_W     = 5;
  localparam int MAN_W     = 6;
  localparam int BIAS      = 15;
  localparam int OUT_MAN_W = 10;

  localparam logic [15:0] FP16_INF  = 16'h7C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUBNORM,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp12_class_e;

  // Fraction of 2/(1+m/64) scaled to 10 bits, rounded to nearest; m=0 is the exact power-of-two case.
  function automatic logic [OUT_MAN_W-1:0] recip_entry(input int m);
    int q;
    if (m == 0) return '0;
    q = (262144 / (64 + m) + 1) / 2;
    return OUT_MAN_W'(q - 1024);
  endfunction

endpackage

// File: rtl/fp12_recip_lut.sv
// Combinational 64-entry reciprocal mantissa table; entries are elaboration-time constants.
module fp12_recip_lut
  import fp12_pkg::*;
(
  input  logic [MAN_W-1:0]     m,
  output logic [OUT_MAN_W-1:0] recip
);

  logic [OUT_MAN_W-1:0] rom [64];

  for (genvar i = 0; i < 64; i++) begin : g_rom
    assign rom[i] = recip_entry(i);
  end

  assign recip = rom[m];

endmodule

// File: rtl/fp12_inverse.sv
// Registered 1/a: FP12 (1/5/6, bias 15) in, IEEE binary16 out, one cycle latency.
// Define FP12_INV_SUBNORM_EN to normalize subnormal inputs instead of treating them as zero.
module fp12_inverse
  import fp12_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] a,
  input  logic        in_valid,
  output logic [15:0] b,
  output logic        out_valid
);

  logic                 sign;
  logic [EXP_W-1:0]     e;
  logic [MAN_W-1:0]     m;
  fp12_class_e          cls;
  logic [MAN_W-1:0]     lut_in;
  logic [OUT_MAN_W-1:0] lut_out;
  int                   field;
  int                   shift;
  logic [OUT_MAN_W+1:0] ext;
  logic [OUT_MAN_W:0]   rnd;
  logic [15:0]          b_nxt;

  assign sign = a[11];
  assign e    = a[10:6];
  assign m    = a[5:0];

`ifdef FP12_INV_SUBNORM_EN
  logic [2:0]       lead;
  logic [MAN_W-1:0] frac;

  always_comb begin
    lead = '0;
    for (int i = 0; i < MAN_W; i++) begin
      if (m[i]) lead = 3'(i);
    end
    // Shift the leading one out; the remaining bits are the hidden-one fraction.
    frac = m << (3'd6 - lead);
  end

  assign lut_in = (cls == CLS_SUBNORM) ? frac : m;
`else
  assign lut_in = m;
`endif

  fp12_recip_lut u_lut (
    .m     (lut_in),
    .recip (lut_out)
  );

  always_comb begin
    // NOTE: every combinational output is assigned a default first so no path can infer a latch.
    cls = CLS_NORMAL;
    if (e == '1) begin
      cls = (m == '0) ? CLS_INF : CLS_NAN;
    end else if (e == '0) begin
`ifdef FP12_INV_SUBNORM_EN
      cls = (m == '0) ? CLS_ZERO : CLS_SUBNORM;
`else
      cls = CLS_ZERO;
`endif
    end
  end

  // Non-power-of-two significands land one binade lower, hence the extra -1.
  always_comb begin
    field = 2 * BIAS - int'(e) - ((m == '0) ? 0 : 1);
`ifdef FP12_INV_SUBNORM_EN
    if (cls == CLS_SUBNORM) field = 2 * BIAS + 5 - int'(lead) - ((frac == '0) ? 0 : 1);
`endif
  end

  always_comb begin
    shift = 1 - field;
    ext   = '0;
    rnd   = '0;
    b_nxt = {sign, FP16_INF[14:0]};
    unique case (cls)
      CLS_ZERO: b_nxt = {sign, FP16_INF[14:0]};
      CLS_INF:  b_nxt = {sign, 15'h0000};
      CLS_NAN:  b_nxt = {sign, FP16_QNAN[14:0]};
      default: begin
        if (field >= 31) begin
          b_nxt = {sign, FP16_INF[14:0]};
        end else if (field >= 1) begin
          b_nxt = {sign, field[4:0], lut_out};
        end else begin
          // Keep one guard bit below the LSB; a carry out of rnd promotes to the smallest normal.
          ext   = {1'b1, lut_out, 1'b0} >> shift;
          rnd   = ext[OUT_MAN_W+1:1] + {{OUT_MAN_W{1'b0}}, ext[0]};
          b_nxt = {sign, 4'b0000, rnd};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) b <= b_nxt;
    end
  end

endmodule

// File: tb/tb_fp12_inverse.sv
// Self-checking bench for fp12_inverse against a real-arithmetic reciprocal model.
// Build with FP12_INV_SUBNORM_EN defined to exercise the subnormal-input path.
module tb_fp12_inverse;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] a = '0;
  logic        in_valid = 1'b0;
  logic [15:0] b;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  fp12_inverse dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .in_valid  (in_valid),
    .b         (b),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  // Magnitude of an FP12 code as a real; 0.0 for zero, flushed subnormals, inf and NaN.
  function automatic real fp12_mag(input logic [11:0] code);
    int e, m;
    e = int'(code[10:6]);
    m = int'(code[5:0]);
    if (e == 31) return 0.0;
    if (e == 0) begin
`ifdef FP12_INV_SUBNORM_EN
      return real'(m) / 64.0 * pow2(-14);
`else
      return 0.0;
`endif
    end
    return (1.0 + real'(m) / 64.0) * pow2(e - 15);
  endfunction

  function automatic logic [15:0] model_inv(input logic [11:0] code);
    logic s;
    int   m, k, sig, field, den;
    real  x, r;
    s = code[11];
    m = int'(code[5:0]);
    if (code[10:6] == 5'd31) return (m == 0) ? {s, 15'h0000} : {s, 15'h7E00};
    x = fp12_mag(code);
    if (x == 0.0) return {s, 15'h7C00};
    r = 1.0 / x;
    k = 0;
    while (r >= 2.0) begin r = r / 2.0; k++; end
    while (r < 1.0)  begin r = r * 2.0; k--; end
    sig = int'($floor(r * 1024.0 + 0.5));
    if (sig == 2048) begin sig = 1024; k++; end
    field = k + 15;
    if (field >= 31) return {s, 15'h7C00};
    if (field >= 1)  return {s, 5'(field), 10'(sig - 1024)};
    den = int'($floor(real'(sig) / pow2(1 - field) + 0.5));
    return {s, 15'(den)};
  endfunction

  function automatic real fp16_normal_val(input logic [15:0] h);
    return pow2(int'(h[14:10]) - 15) * (1.0 + real'(int'(h[9:0])) / 1024.0);
  endfunction

  task automatic step(input logic [11:0] code, input logic v);
    @(negedge clk);
    a        = code;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (b !== 16'h0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: b=%h out_valid=%b, want b=0000 out_valid=0", b, out_valid);
    end
    step(12'h3C0, 1'b1);
    n_checks++;
    if (b !== 16'h0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: b=%h out_valid=%b, want b=0000 out_valid=0", b, out_valid);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    step(12'h3C0, 1'b0);
    n_checks++;
    if (b !== 16'h0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: b=%h out_valid=%b, want b=0000 out_valid=0", b, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [11:0] codes [13];
    logic [15:0] want  [13];
    codes = '{12'h3C0, 12'h400, 12'h3E0, 12'hBE0, 12'h000, 12'h800, 12'h7C0,
              12'h7C1, 12'h780, 12'h020, 12'h001, 12'h7A0, 12'hFC0};
    want  = '{16'h3C00, 16'h3800, 16'h3955, 16'hB955, 16'h7C00, 16'hFC00, 16'h0000,
              16'h7E00, 16'h0200,
`ifdef FP12_INV_SUBNORM_EN
              16'h7800,
`else
              16'h7C00,
`endif
              16'h7C00, 16'h0155, 16'h8000};
    for (int i = 0; i < 13; i++) begin
      step(codes[i], 1'b1);
      n_checks++;
      if (b !== want[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL directed a=%h: b=%h out_valid=%b, want b=%h out_valid=1",
                 codes[i], b, out_valid, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    step(12'h3E0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(12'($urandom), 1'b0);
      n_checks++;
      if (b !== 16'h3955 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold: b=%h out_valid=%b, want b=3955 out_valid=0", b, out_valid);
      end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] exp_b;
    real         mag, err;
    int          fld;
    for (int i = 0; i < 2048; i++) begin
      step(12'(i), 1'b1);
      exp_b = model_inv(12'(i));
      n_checks++;
      if (b !== exp_b || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep a=%h: b=%h out_valid=%b, want b=%h out_valid=1", 12'(i), b, out_valid, exp_b);
      end
      mag = fp12_mag(12'(i));
      fld = int'(exp_b[14:10]);
      if (mag > 0.0 && fld >= 1 && fld <= 30) begin
        err = fp16_normal_val(b) - 1.0 / mag;
        if (err < 0.0) err = -err;
        n_checks++;
        if (!(err <= 0.5 * pow2(fld - 25))) begin
          n_fail++;
          $display("FAIL sweep_ulp a=%h: b=%h error=%g, want error<=%g", 12'(i), b, err, 0.5 * pow2(fld - 25));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] code;
    logic        v;
    logic [15:0] last_b;
    last_b = b;
    for (int i = 0; i < 400; i++) begin
      code = 12'($urandom);
      v    = ($urandom_range(3) != 0);
      step(code, v);
      if (v) last_b = model_inv(code);
      n_checks++;
      if (b !== last_b || out_valid !== v) begin
        n_fail++;
        $display("FAIL random a=%h v=%b: b=%h out_valid=%b, want b=%h out_valid=%b",
                 code, v, b, out_valid, last_b, v);
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(12'h3E0, 1'b1);
    @(negedge clk);
    a        = 12'h400;
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (b !== 16'h0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midstream_async: b=%h out_valid=%b, want b=0000 out_valid=0", b, out_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (b !== 16'h0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midstream_discard: b=%h out_valid=%b, want b=0000 out_valid=0", b, out_valid);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (b !== 16'h0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midstream_release: b=%h out_valid=%b, want b=0000 out_valid=0", b, out_valid);
    end
    step(12'h400, 1'b1);
    n_checks++;
    if (b !== 16'h3800 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midstream_first: b=%h out_valid=%b, want b=3800 out_valid=1", b, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_sweep();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
